// File: rtl/pwm_fade_sequencer.sv
// Purpose: sequences a pwm duty word through ramp-up / hold / ramp-down / hold "breathing" cycles.
// Latency: every output is registered; a start seen in IDLE shows up on the next clock edge.
// Backpressure: none; stop aborts on the next edge, and start is ignored while a sequence runs.
module pwm_fade_sequencer #(
  parameter int N        = 8,
  parameter int STEP_DIV = 16,
  parameter int CW       = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic [CW-1:0] ramp_rate,
  input  logic [CW-1:0] hold,
  input  logic [7:0]    cycles,
  output logic          pwm_ena,
  output logic          pwm_step,
  output logic [N-1:0]  duty,
  output logic          busy,
  output logic          done,
  output logic [2:0]    state
);

  localparam logic [N-1:0]  DUTY_MAX = '1;
  localparam int            PW       = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST  = PW'(STEP_DIV - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP_UP   = 3'd1,
    HOLD_HIGH = 3'd2,
    RAMP_DOWN = 3'd3,
    HOLD_LOW  = 3'd4
  } st_t;

  st_t           st_q, st_d;
  logic [N-1:0]  duty_q, duty_d;
  logic          ena_q, ena_d;
  logic          step_q, step_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [PW-1:0] ps_q, ps_d;
  logic [CW-1:0] rate_cnt_q, rate_cnt_d;
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;
  logic [7:0]    cyc_cnt_q, cyc_cnt_d;
  // Configuration captured at start; rate and hold are stored already forced to >= 1.
  logic [CW-1:0] rate_l_q, rate_l_d;
  logic [CW-1:0] hold_l_q, hold_l_d;
  logic [7:0]    cycles_l_q, cycles_l_d;

  logic          rate_tick;
  logic          hold_end;
  logic [7:0]    cyc_inc;

  assign rate_tick = (rate_cnt_q == rate_l_q - 1'b1);
  assign hold_end  = (hold_cnt_q == hold_l_q - 1'b1);
  // In run-forever mode the completed-cycle count parks at 255 instead of wrapping.
  assign cyc_inc   = (cyc_cnt_q == 8'hFF) ? 8'hFF : cyc_cnt_q + 8'd1;

  // Next-state and next-output logic for the fade sequence, stop override and step prescaler.
  always_comb begin
    st_d       = st_q;
    duty_d     = duty_q;
    ena_d      = ena_q;
    done_d     = 1'b0;
    step_d     = 1'b0;
    busy_d     = busy_q;
    ps_d       = ps_q;
    rate_cnt_d = rate_cnt_q;
    hold_cnt_d = hold_cnt_q;
    cyc_cnt_d  = cyc_cnt_q;
    rate_l_d   = rate_l_q;
    hold_l_d   = hold_l_q;
    cycles_l_d = cycles_l_q;

    case (st_q)
      IDLE: begin
        if (start && !stop) begin
          st_d       = RAMP_UP;
          rate_l_d   = (ramp_rate == '0) ? CW'(1) : ramp_rate;
          hold_l_d   = (hold == '0) ? CW'(1) : hold;
          cycles_l_d = cycles;
          duty_d     = '0;
          ena_d      = 1'b1;
          cyc_cnt_d  = 8'd0;
          rate_cnt_d = '0;
          hold_cnt_d = '0;
        end
      end
      RAMP_UP: begin
        if (rate_tick) begin
          rate_cnt_d = '0;
          if (duty_q == DUTY_MAX) begin
            st_d       = HOLD_HIGH;
            hold_cnt_d = '0;
          end else begin
            duty_d = duty_q + 1'b1;
          end
        end else begin
          rate_cnt_d = rate_cnt_q + 1'b1;
        end
      end
      HOLD_HIGH: begin
        if (hold_end) begin
          st_d       = RAMP_DOWN;
          hold_cnt_d = '0;
          rate_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      RAMP_DOWN: begin
        if (rate_tick) begin
          rate_cnt_d = '0;
          if (duty_q == '0) begin
            st_d       = HOLD_LOW;
            hold_cnt_d = '0;
          end else begin
            duty_d = duty_q - 1'b1;
          end
        end else begin
          rate_cnt_d = rate_cnt_q + 1'b1;
        end
      end
      HOLD_LOW: begin
        if (hold_end) begin
          hold_cnt_d = '0;
          cyc_cnt_d  = cyc_inc;
          if ((cycles_l_q != 8'd0) && (cyc_inc == cycles_l_q)) begin
            st_d   = IDLE;
            ena_d  = 1'b0;
            duty_d = '0;
            done_d = 1'b1;
          end else begin
            st_d       = RAMP_UP;
            rate_cnt_d = '0;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: begin
        st_d   = IDLE;
        ena_d  = 1'b0;
        duty_d = '0;
      end
    endcase

    // An abort wins over whatever transition the sequence wanted this edge.
    if ((st_q != IDLE) && stop) begin
      st_d       = IDLE;
      duty_d     = '0;
      ena_d      = 1'b0;
      done_d     = 1'b0;
      rate_cnt_d = '0;
      hold_cnt_d = '0;
      cyc_cnt_d  = 8'd0;
    end

    busy_d = (st_d != IDLE);

    // Prescaler phase is counted from the first busy clock and never runs in IDLE.
    if (st_d == IDLE) begin
      ps_d = '0;
    end else if (st_q == IDLE) begin
      ps_d = '0;
    end else begin
      ps_d = (ps_q == PS_LAST) ? '0 : ps_q + 1'b1;
    end
    step_d = (st_d != IDLE) && (ps_d == PS_LAST);
  end

  // State, output and counter registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q       <= IDLE;
      duty_q     <= '0;
      ena_q      <= 1'b0;
      step_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ps_q       <= '0;
      rate_cnt_q <= '0;
      hold_cnt_q <= '0;
      cyc_cnt_q  <= 8'd0;
      rate_l_q   <= '0;
      hold_l_q   <= '0;
      cycles_l_q <= 8'd0;
    end else begin
      st_q       <= st_d;
      duty_q     <= duty_d;
      ena_q      <= ena_d;
      step_q     <= step_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ps_q       <= ps_d;
      rate_cnt_q <= rate_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      cyc_cnt_q  <= cyc_cnt_d;
      rate_l_q   <= rate_l_d;
      hold_l_q   <= hold_l_d;
      cycles_l_q <= cycles_l_d;
    end
  end

  assign pwm_ena  = ena_q;
  assign pwm_step = step_q;
  assign duty     = duty_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign state    = st_q;

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Purpose: scoreboard bench for pwm_fade_sequencer against a phase-list model of the breathe sequence.
// Latency: expected outputs are tagged with the absolute clock they must appear in.
// Backpressure: n/a; the monitor compares one record per clock whenever one is queued for it.
module tb_pwm_fade_sequencer;

  localparam int N    = 4;
  localparam int SD   = 4;
  localparam int CW   = 16;
  localparam int MAXV = (1 << N) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [CW-1:0] ramp_rate = '0;
  logic [CW-1:0] hold = '0;
  logic [7:0]    cycles = 8'd0;
  logic          pwm_ena, pwm_step, busy, done;
  logic [N-1:0]  duty;
  logic [2:0]    state;

  pwm_fade_sequencer #(.N(N), .STEP_DIV(SD), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .ramp_rate(ramp_rate), .hold(hold), .cycles(cycles),
    .pwm_ena(pwm_ena), .pwm_step(pwm_step), .duty(duty),
    .busy(busy), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  int cyc_now = 0;
  // Absolute clock index: the interval after the k-th rising edge is clock k.
  always @(posedge clk) cyc_now <= cyc_now + 1;

  typedef struct {
    int           cyc;
    logic [2:0]   st;
    logic [N-1:0] duty;
    logic         ena;
    logic         step;
    logic         busy;
    logic         done;
  } exp_t;

  exp_t sb_q[$];
  exp_t tr_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic exp_t idle_rec(input int c, input bit dn);
    exp_t e;
    e.cyc = c; e.st = 3'd0; e.duty = '0; e.ena = 1'b0;
    e.step = 1'b0; e.busy = 1'b0; e.done = dn;
    return e;
  endfunction

  // One busy clock; the pwm step falls on every SD-th busy clock counted from the start.
  function automatic void add_busy(input int st, input int d);
    exp_t e;
    int   k;
    k = tr_q.size();
    e.cyc = 0; e.st = 3'(st); e.duty = N'(d); e.ena = 1'b1;
    e.busy = 1'b1; e.done = 1'b0;
    e.step = ((k % SD) == SD - 1);
    tr_q.push_back(e);
  endfunction

  // Expected clock-by-clock trace of a sequence, cut to at most 'limit' clocks.
  function automatic void build_trace(input int r, input int h, input int cy, input int limit);
    int re, he, bc;
    re = (r == 0) ? 1 : r;
    he = (h == 0) ? 1 : h;
    bc = 0;
    tr_q.delete();
    while (tr_q.size() < limit) begin
      for (int d = 0; d <= MAXV; d++)
        for (int j = 0; j < re; j++) add_busy(1, d);
      for (int j = 0; j < he; j++) add_busy(2, MAXV);
      for (int d = MAXV; d >= 0; d--)
        for (int j = 0; j < re; j++) add_busy(3, d);
      for (int j = 0; j < he; j++) add_busy(4, 0);
      bc++;
      if (cy != 0 && bc == cy) begin
        tr_q.push_back(idle_rec(0, 1'b1));
        break;
      end
    end
    while (tr_q.size() > limit) void'(tr_q.pop_back());
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc_now < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compare the DUT against the record queued for the current clock.
  always @(negedge clk) begin
    exp_t e;
    while (sb_q.size() > 0 && sb_q[0].cyc < cyc_now) begin
      e = sb_q.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL stale_record: clock %0d expectation never compared (now %0d)", e.cyc, cyc_now);
    end
    if (sb_q.size() > 0 && sb_q[0].cyc == cyc_now) begin
      e = sb_q.pop_front();
      n_tests++;
      if (state !== e.st || duty !== e.duty || pwm_ena !== e.ena || pwm_step !== e.step ||
          busy !== e.busy || done !== e.done) begin
        n_fail++;
        $display("FAIL trace clk=%0d: got st=%0d duty=%0d ena=%b step=%b busy=%b done=%b, want st=%0d duty=%0d ena=%b step=%b busy=%b done=%b",
                 cyc_now, state, duty, pwm_ena, pwm_step, busy, done,
                 e.st, e.duty, e.ena, e.step, e.busy, e.done);
      end
    end
  end

  // Launch one sequence; stop_len>0 aborts after that many busy clocks, poke_at>0 re-pulses start mid-run.
  task automatic do_run(input int r, input int h, input int cy, input int stop_len,
                        input int poke_at, input int new_rate);
    int   s, len;
    exp_t e;
    ramp_rate = CW'(r); hold = CW'(h); cycles = 8'(cy); start = 1'b1; stop = 1'b0;
    s = cyc_now + 1;
    build_trace(r, h, cy, (stop_len > 0) ? stop_len : 32'h7fff_ffff);
    len = tr_q.size();
    for (int i = 0; i < len; i++) begin
      e = tr_q[i];
      e.cyc = s + i;
      sb_q.push_back(e);
    end
    for (int i = 0; i < 3; i++) sb_q.push_back(idle_rec(s + len + i, 1'b0));
    wait_cyc(s);
    start = 1'b0;
    ramp_rate = CW'(new_rate);
    hold = CW'($urandom_range(0, 9));
    cycles = 8'($urandom_range(0, 5));
    if (poke_at > 0) begin
      wait_cyc(s + poke_at - 1);
      start = 1'b1;
      wait_cyc(s + poke_at);
      start = 1'b0;
    end
    if (stop_len > 0) begin
      wait_cyc(s + stop_len - 1);
      stop = 1'b1;
      wait_cyc(s + stop_len);
      stop = 1'b0;
    end
    wait_cyc(s + len + 2);
  endtask

  // Asynchronous reset in the middle of a ramp, while duty is 7.
  task automatic reset_mid_ramp();
    int   s, i;
    exp_t e;
    ramp_rate = CW'(2); hold = CW'(3); cycles = 8'd1; start = 1'b1;
    s = cyc_now + 1;
    i = 7 * 2 + 1;
    build_trace(2, 3, 1, i);
    for (int k = 0; k < i; k++) begin
      e = tr_q[k];
      e.cyc = s + k;
      sb_q.push_back(e);
    end
    for (int k = 0; k < 4; k++) sb_q.push_back(idle_rec(s + i + k, 1'b0));
    wait_cyc(s);
    start = 1'b0;
    wait_cyc(s + i);
    #1;
    chk("pre_reset_duty", 32'(duty), 32'd7);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_duty",  32'(duty),    32'd0);
    chk("async_rst_ena",   32'(pwm_ena), 32'd0);
    chk("async_rst_busy",  32'(busy),    32'd0);
    chk("async_rst_state", 32'(state),   32'd0);
    chk("async_rst_done",  32'(done),    32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_cyc(s + i + 3);
  endtask

  task automatic start_stop_idle();
    int s;
    ramp_rate = CW'(1); hold = CW'(1); cycles = 8'd1;
    start = 1'b1; stop = 1'b1;
    s = cyc_now + 1;
    for (int i = 0; i < 3; i++) sb_q.push_back(idle_rec(s + i, 1'b0));
    wait_cyc(s);
    start = 1'b0; stop = 1'b0;
    wait_cyc(s + 2);
  endtask

  initial begin
    for (int i = 1; i <= 4; i++) sb_q.push_back(idle_rec(i, 1'b0));
    #1;
    chk("reset_duty",  32'(duty),     32'd0);
    chk("reset_ena",   32'(pwm_ena),  32'd0);
    chk("reset_step",  32'(pwm_step), 32'd0);
    chk("reset_busy",  32'(busy),     32'd0);
    chk("reset_done",  32'(done),     32'd0);
    chk("reset_state", 32'(state),    32'd0);
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(4);

    do_run(2, 3, 1, 0, 0, 2);                         // single breathe cycle, 70 clocks
    do_run(0, 0, 2, 0, 0, 0);                         // zero config acts as rate=1, hold=1
    reset_mid_ramp();
    do_run(2, 3, 0, 16 * 2 + 1, 0, 2);                // stop in first HOLD_HIGH clock
    start_stop_idle();
    do_run(2, 3, 0, 4 * 70 + 7, 16 * 2 + 3 + 5, 5);   // rate change ignored, start poke in RAMP_DOWN

    for (int t = 0; t < 6; t++) begin
      int r, h, cy, per, sl;
      r  = int'($urandom_range(0, 3));
      h  = int'($urandom_range(0, 4));
      cy = int'($urandom_range(1, 2));
      per = 2 * (MAXV + 1) * ((r == 0) ? 1 : r) + 2 * ((h == 0) ? 1 : h);
      sl = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, cy * per)) : 0;
      do_run(r, h, cy, sl, 0, int'($urandom_range(0, 7)));
    end

    do_run(0, 0, 0, 300 * 34 + 10, 0, 3);             // run forever past cycle-count saturation

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #600000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: simulation still running at time %0t, limit 600000", $time);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
